// File: rtl/uart_rx_pkt_ctrl.sv
// Purpose: drains the RX FIFO, parses SYNC/LEN/payload/XOR-checksum frames, streams payload downstream.
// Latency: a byte is consumed one clock after RDo (peak 1 byte / 2 clocks); payload shows on PKT_DATAo next cycle.
// Backpressure: PKT_READYi low holds the output byte, stalls FIFO reads in payload and freezes the timeout.
// Ports: FIFO read side (EMPTYi, RDo, DATAi), baud config (CFG_BAUDi, CFG_WEi, BAUD_RATEo, BAUD_RATE_WEo),
//        packet stream (PKT_DATAo/VALIDo/READYi/LASTo/DONEo/ERRo), BUSYo.
// Optional: define UART_PKT_STATS_EN to add STAT_PKTSo / STAT_ERRSo saturating frame counters.
module uart_rx_pkt_ctrl #(
    parameter int         DATA_WIDTH     = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 64,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                  CLKip,
    input  logic                  RSTi,
    input  logic                  EMPTYi,
    output logic                  RDo,
    input  logic [DATA_WIDTH-1:0] DATAi,
    input  logic [31:0]           CFG_BAUDi,
    input  logic                  CFG_WEi,
    output logic [31:0]           BAUD_RATEo,
    output logic                  BAUD_RATE_WEo,
    output logic [DATA_WIDTH-1:0] PKT_DATAo,
    output logic                  PKT_VALIDo,
    input  logic                  PKT_READYi,
    output logic                  PKT_LASTo,
    output logic                  PKT_DONEo,
    output logic [1:0]            PKT_ERRo,
    output logic                  BUSYo
`ifdef UART_PKT_STATS_EN
    ,
    output logic [15:0]           STAT_PKTSo,
    output logic [15:0]           STAT_ERRSo
`endif
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] MAX_LEN_B = DATA_WIDTH'(MAX_LEN);
    localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]           BAUD_RST  = 32'd115200;
    localparam logic [1:0] ERR_OK = 2'b00, ERR_CSUM = 2'b01, ERR_TMO = 2'b10, ERR_LEN = 2'b11;

    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CSUM, DONE} state_t;

    state_t                state_q, state_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  vld_q, vld_d;
    logic                  last_q, last_d;
    logic [1:0]            err_q, err_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [31:0]           baud_q, baud_d;
    logic                  baud_we_q, baud_we_d;
    logic                  req_vld_q, req_vld_d;
    logic [31:0]           req_val_q, req_val_d;

    logic out_free;
    logic apply;
    logic accept;
    logic rd;
    logic timing;
    logic frozen;
    logic tmo_hit;

    always_ff @(posedge CLKip) begin
        if (!RSTi) begin
            state_q   <= HUNT;
            rd_pend_q <= 1'b0;
            cnt_q     <= '0;
            csum_q    <= '0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= ERR_OK;
            tmo_q     <= '0;
            baud_q    <= BAUD_RST;
            baud_we_q <= 1'b0;
            req_vld_q <= 1'b0;
            req_val_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            last_q    <= last_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            baud_q    <= baud_d;
            baud_we_q <= baud_we_d;
            req_vld_q <= req_vld_d;
            req_val_q <= req_val_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        data_d    = data_q;
        vld_d     = vld_q;
        last_d    = last_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        baud_d    = baud_q;
        baud_we_d = 1'b0;
        req_vld_d = req_vld_q;
        req_val_d = req_val_q;

        out_free = !vld_q || PKT_READYi;
        // Baud changes only land between frames, and never while a byte is in flight.
        apply    = req_vld_q && (state_q == HUNT) && !rd_pend_q;

        case (state_q)
            HUNT:    accept = !apply;
            LEN:     accept = 1'b1;
            PAYLOAD: accept = out_free;
            CSUM:    accept = 1'b1;  // compared at once even if the last byte is still held
            default: accept = 1'b0;
        endcase
        rd        = RSTi && !EMPTYi && !rd_pend_q && accept;
        rd_pend_d = rd;

        timing = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CSUM);
        frozen = vld_q && !PKT_READYi;
        // A timeout is suppressed while a read is being issued so its byte is never stranded in DONE.
        tmo_hit = timing && !rd_pend_q && !frozen && !rd && (tmo_q == TMO_LAST);

        if (!timing || rd_pend_q) begin
            tmo_d = '0;
        end else if (!frozen && (tmo_q != TMO_LAST)) begin
            tmo_d = tmo_q + 1'b1;
        end

        if (vld_q && PKT_READYi) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end

        case (state_q)
            HUNT: begin
                if (rd_pend_q && (DATAi == SYNC_BYTE)) state_d = LEN;
            end
            LEN: begin
                if (rd_pend_q) begin
                    if ((DATAi == '0) || (DATAi > MAX_LEN_B)) begin
                        err_d   = ERR_LEN;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_W'(DATAi);
                        csum_d  = DATAi;
                        state_d = PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    err_d   = ERR_TMO;
                    state_d = DONE;
                end
            end
            PAYLOAD: begin
                if (rd_pend_q) begin
                    data_d = DATAi;
                    vld_d  = 1'b1;
                    last_d = (cnt_q == CNT_W'(1));
                    csum_d = csum_q ^ DATAi;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = CSUM;
                end else if (tmo_hit) begin
                    err_d   = ERR_TMO;
                    state_d = DONE;
                end
            end
            CSUM: begin
                if (rd_pend_q) begin
                    err_d   = (DATAi == csum_q) ? ERR_OK : ERR_CSUM;
                    state_d = DONE;
                end else if (tmo_hit) begin
                    err_d   = ERR_TMO;
                    state_d = DONE;
                end
            end
            DONE: begin
                // The end-of-frame pulse waits until the final payload byte has left.
                if (!vld_q) state_d = HUNT;
            end
            default: state_d = HUNT;
        endcase

        if (apply) begin
            req_vld_d = 1'b0;
            if (req_val_q != '0) begin
                baud_d    = req_val_q;
                baud_we_d = 1'b1;
            end
        end
        // A new request in the apply cycle overrides the clear and stays pending.
        if (CFG_WEi) begin
            req_vld_d = 1'b1;
            req_val_d = CFG_BAUDi;
        end
    end

    assign RDo           = rd;
    assign PKT_DATAo     = data_q;
    assign PKT_VALIDo    = vld_q;
    assign PKT_LASTo     = last_q;
    assign PKT_DONEo     = (state_q == DONE) && !vld_q;
    assign PKT_ERRo      = err_q;
    assign BAUD_RATEo    = baud_q;
    assign BAUD_RATE_WEo = baud_we_q;
    assign BUSYo         = (state_q != HUNT) || rd_pend_q;

`ifdef UART_PKT_STATS_EN
    always_ff @(posedge CLKip) begin
        if (!RSTi) begin
            STAT_PKTSo <= '0;
            STAT_ERRSo <= '0;
        end else if (PKT_DONEo) begin
            if (PKT_ERRo == ERR_OK) begin
                if (STAT_PKTSo != 16'hFFFF) STAT_PKTSo <= STAT_PKTSo + 16'd1;
            end else begin
                if (STAT_ERRSo != 16'hFFFF) STAT_ERRSo <= STAT_ERRSo + 16'd1;
            end
        end
    end
`endif

endmodule
